// File: rtl/spi_port_regs_pkg.sv
// Shared definitions for the PicoBlaze SPI register block: register map,
// interrupt bit positions and the burst controller state encoding.
package spi_port_regs_pkg;

    localparam logic [3:0] OFF_SPCR        = 4'h0;
    localparam logic [3:0] OFF_SPSR        = 4'h1;
    localparam logic [3:0] OFF_SPDR        = 4'h2;
    localparam logic [3:0] OFF_SPER        = 4'h3;
    localparam logic [3:0] OFF_NCS         = 4'h4;
    localparam logic [3:0] OFF_IER         = 4'h5;
    localparam logic [3:0] OFF_ISR         = 4'h6;
    localparam logic [3:0] OFF_BURST       = 4'h7;
    localparam logic [3:0] OFF_SENSOR_BASE = 4'h8;

    localparam int ISR_SPIF  = 0;
    localparam int ISR_WCOL  = 1;
    localparam int ISR_BURST = 2;
    localparam int ISR_W     = 3;

    localparam int SENSOR_W    = 16;
    localparam int MAX_CS      = 7;
    localparam int MAX_SENSORS = 4;

    typedef enum logic [1:0] {
        BURST_IDLE  = 2'd0,
        BURST_COUNT = 2'd1,
        BURST_DRAIN = 2'd2
    } burst_state_t;

endpackage

// File: rtl/spi_port_regs_if.sv
// Processor port bus (port_id / in_port / out_port with access strobes).
interface spi_port_regs_if;
    logic [7:0] port_id;
    logic [7:0] data_in;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] data_out;

    modport master (
        output port_id,
        output data_in,
        output write_strobe,
        output read_strobe,
        input  data_out
    );

    modport slave (
        input  port_id,
        input  data_in,
        input  write_strobe,
        input  read_strobe,
        output data_out
    );
endinterface

// File: rtl/spi_port_regs_burst_ctrl.sv
// Burst counter: counts SPDR writes down to zero, then waits for the final
// transfer's SPIF before signalling completion and optional chip-select release.
module spi_burst_ctrl
    import spi_port_regs_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       burst_wr,
    input  logic [7:0] burst_data,
    input  logic       spdr_wr,
    input  logic       spif,
    input  logic       auto_release,
    output logic       spif_rise,
    output logic       burst_done,
    output logic       cs_release,
    output logic [7:0] count
);

    burst_state_t state_reg;
    logic [7:0]   count_reg;
    logic         spif_prev_reg;
    logic         done_reg;
    logic         cs_release_reg;

    // History resets low, so an SPIF already high out of reset reads as an edge.
    assign spif_rise  = spif & ~spif_prev_reg;
    assign burst_done = done_reg;
    assign cs_release = cs_release_reg;
    assign count      = count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg      <= BURST_IDLE;
            count_reg      <= 8'd0;
            spif_prev_reg  <= 1'b0;
            done_reg       <= 1'b0;
            cs_release_reg <= 1'b0;
        end else begin
            spif_prev_reg  <= spif;
            done_reg       <= 1'b0;
            cs_release_reg <= 1'b0;
            // A BURST write pre-empts whatever the FSM would have done this cycle.
            if (burst_wr) begin
                count_reg <= burst_data;
                state_reg <= (burst_data != 8'd0) ? BURST_COUNT : BURST_IDLE;
            end else begin
                case (state_reg)
                    BURST_COUNT: begin
                        if (spdr_wr) begin
                            count_reg <= count_reg - 8'd1;
                            if (count_reg == 8'd1) begin
                                state_reg <= BURST_DRAIN;
                            end
                        end
                    end
                    BURST_DRAIN: begin
                        if (spif_rise) begin
                            state_reg      <= BURST_IDLE;
                            done_reg       <= 1'b1;
                            cs_release_reg <= auto_release;
                        end
                    end
                    default: begin
                        state_reg <= BURST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/spi_port_regs.sv
// PicoBlaze-side register file for the SPI master: control/status/FIFO access,
// chip selects, atomic 16-bit sensor registers, burst control and interrupts.
module spi_port_regs
    import spi_port_regs_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDRESS = 8'h00,
    parameter int          NUM_CS       = 1,
    parameter int          NUM_SENSORS  = 1,
    parameter logic [15:0] SENSOR_RESET = 16'h0000
) (
    input  logic                            clk,
    input  logic                            reset,
    spi_port_regs_if.slave                  bus,
    output logic [7:0]                      spcr,
    output logic [7:0]                      sper,
    input  logic [7:0]                      spsr,
    output logic                            wr_spsr,
    output logic                            clear_spif,
    output logic                            clear_wcol,
    output logic [7:0]                      wfdin,
    output logic                            wfwe,
    input  logic [7:0]                      rfdout,
    output logic                            rfre,
    output logic [NUM_CS-1:0]               ncs_o,
    output logic [SENSOR_W*NUM_SENSORS-1:0] sensor,
    output logic                            irq
);

    if (NUM_CS < 1 || NUM_CS > MAX_CS) begin : g_bad_num_cs
        $error("spi_port_regs: NUM_CS must be in 1..7");
    end
    if (NUM_SENSORS < 1 || NUM_SENSORS > MAX_SENSORS) begin : g_bad_num_sensors
        $error("spi_port_regs: NUM_SENSORS must be in 1..4");
    end

    // Address decode: 9-bit subtraction so ports below the base never alias in.
    logic [8:0] addr_diff;
    logic       hit;
    logic [3:0] offset;
    logic       wr_hit;
    logic       rd_hit;
    logic       sens_sel;
    logic [1:0] sens_idx;
    logic       sens_hi;

    assign addr_diff = {1'b0, bus.port_id} - {1'b0, BASE_ADDRESS};
    assign hit       = (addr_diff[8:4] == 5'd0);
    assign offset    = addr_diff[3:0];
    assign wr_hit    = bus.write_strobe & hit;
    assign rd_hit    = bus.read_strobe & hit;
    assign sens_idx  = offset[2:1];
    assign sens_hi   = offset[0];
    assign sens_sel  = hit && offset[3] && (int'(sens_idx) < NUM_SENSORS);

    logic we_spcr, we_spsr, we_spdr, we_sper, we_ncs, we_ier, we_isr, we_burst;
    logic we_sens_lo, we_sens_hi, re_spdr, re_sens_lo;

    assign we_spcr    = wr_hit && (offset == OFF_SPCR);
    assign we_spsr    = wr_hit && (offset == OFF_SPSR);
    assign we_spdr    = wr_hit && (offset == OFF_SPDR);
    assign we_sper    = wr_hit && (offset == OFF_SPER);
    assign we_ncs     = wr_hit && (offset == OFF_NCS);
    assign we_ier     = wr_hit && (offset == OFF_IER);
    assign we_isr     = wr_hit && (offset == OFF_ISR);
    assign we_burst   = wr_hit && (offset == OFF_BURST);
    assign we_sens_lo = bus.write_strobe && sens_sel && !sens_hi;
    assign we_sens_hi = bus.write_strobe && sens_sel && sens_hi;
    assign re_spdr    = rd_hit && (offset == OFF_SPDR);
    assign re_sens_lo = bus.read_strobe && sens_sel && !sens_hi;

    logic [7:0]        spcr_reg, sper_reg, wfdin_reg, data_out_reg;
    logic              wr_spsr_reg, clear_spif_reg, clear_wcol_reg, wfwe_reg, rfre_reg;
    logic [NUM_CS-1:0] ncs_reg;
    logic              auto_reg;
    logic [ISR_W-1:0]  ier_reg, isr_reg, isr_set, isr_w1c, isr_next;
    logic              irq_reg;
    logic              wcol_prev_reg;
    logic [7:0]        wr_shadow_reg, rd_shadow_reg;

    logic       spif_rise, burst_done, cs_release;
    logic [7:0] burst_count;

    spi_burst_ctrl u_burst (
        .clk          (clk),
        .srst         (reset),
        .burst_wr     (we_burst),
        .burst_data   (bus.data_in),
        .spdr_wr      (we_spdr),
        .spif         (spsr[7]),
        .auto_release (auto_reg),
        .spif_rise    (spif_rise),
        .burst_done   (burst_done),
        .cs_release   (cs_release),
        .count        (burst_count)
    );

    // Set terms are OR-ed in after the clear so a same-cycle event is never lost.
    always_comb begin
        isr_set            = '0;
        isr_set[ISR_SPIF]  = spif_rise;
        isr_set[ISR_WCOL]  = spsr[6] & ~wcol_prev_reg;
        isr_set[ISR_BURST] = burst_done;
        isr_w1c            = we_isr ? bus.data_in[ISR_W-1:0] : '0;
        isr_next           = (isr_reg & ~isr_w1c) | isr_set;
    end

    // Sensor storage; unpopulated slots read as zero through sensor_pad.
    logic [SENSOR_W-1:0] sensor_pad [MAX_SENSORS];

    for (genvar gi = 0; gi < MAX_SENSORS; gi++) begin : g_sensor
        if (gi < NUM_SENSORS) begin : g_live
            logic [SENSOR_W-1:0] value_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    value_reg <= SENSOR_RESET;
                end else if (we_sens_hi && (sens_idx == 2'(gi))) begin
                    value_reg <= {bus.data_in, wr_shadow_reg};
                end
            end
            assign sensor_pad[gi]                      = value_reg;
            assign sensor[SENSOR_W*gi +: SENSOR_W]     = value_reg;
        end else begin : g_absent
            assign sensor_pad[gi] = '0;
        end
    end

    logic [7:0] ncs_rd;
    logic [7:0] rd_mux;

    always_comb begin
        ncs_rd             = '0;
        ncs_rd[NUM_CS-1:0] = ncs_reg;
        ncs_rd[7]          = auto_reg;
    end

    always_comb begin
        rd_mux = 8'h00;
        if (hit) begin
            case (offset)
                OFF_SPCR:  rd_mux = spcr_reg;
                OFF_SPSR:  rd_mux = spsr;
                OFF_SPDR:  rd_mux = rfdout;
                OFF_SPER:  rd_mux = sper_reg;
                OFF_NCS:   rd_mux = ncs_rd;
                OFF_IER:   rd_mux = {5'b0, ier_reg};
                OFF_ISR:   rd_mux = {5'b0, isr_reg};
                OFF_BURST: rd_mux = burst_count;
                default: begin
                    if (sens_sel) begin
                        rd_mux = sens_hi ? rd_shadow_reg : sensor_pad[sens_idx][7:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spcr_reg       <= 8'h00;
            sper_reg       <= 8'h00;
            wfdin_reg      <= 8'h00;
            data_out_reg   <= 8'h00;
            wr_spsr_reg    <= 1'b0;
            clear_spif_reg <= 1'b0;
            clear_wcol_reg <= 1'b0;
            wfwe_reg       <= 1'b0;
            rfre_reg       <= 1'b0;
            ncs_reg        <= '1;
            auto_reg       <= 1'b0;
            ier_reg        <= '0;
            isr_reg        <= '0;
            irq_reg        <= 1'b0;
            wcol_prev_reg  <= 1'b0;
            wr_shadow_reg  <= 8'h00;
            rd_shadow_reg  <= 8'h00;
        end else begin
            wr_spsr_reg    <= we_spsr;
            clear_spif_reg <= we_spsr & bus.data_in[7];
            clear_wcol_reg <= we_spsr & bus.data_in[6];
            wfwe_reg       <= we_spdr;
            rfre_reg       <= re_spdr;
            if (we_spdr) wfdin_reg <= bus.data_in;
            if (we_spcr) spcr_reg  <= bus.data_in;
            if (we_sper) sper_reg  <= bus.data_in;
            if (we_ier)  ier_reg   <= bus.data_in[ISR_W-1:0];
            // Software NCS write overrides a concurrent automatic release.
            if (we_ncs) begin
                ncs_reg  <= bus.data_in[NUM_CS-1:0];
                auto_reg <= bus.data_in[7];
            end else if (cs_release) begin
                ncs_reg <= '1;
            end
            isr_reg       <= isr_next;
            irq_reg       <= |(isr_reg & ier_reg);
            wcol_prev_reg <= spsr[6];
            if (we_sens_lo) wr_shadow_reg <= bus.data_in;
            if (re_sens_lo) rd_shadow_reg <= sensor_pad[sens_idx][15:8];
            data_out_reg  <= rd_mux;
        end
    end

    assign spcr         = spcr_reg;
    assign sper         = sper_reg;
    assign wfdin        = wfdin_reg;
    assign wfwe         = wfwe_reg;
    assign rfre         = rfre_reg;
    assign wr_spsr      = wr_spsr_reg;
    assign clear_spif   = clear_spif_reg;
    assign clear_wcol   = clear_wcol_reg;
    assign ncs_o        = ncs_reg;
    assign irq          = irq_reg;
    assign bus.data_out = data_out_reg;

endmodule

// File: tb/tb_spi_port_regs.sv
// Directed bench for spi_port_regs: register map table plus hand-written
// sequences for pulses, sensor atomicity, bursts and interrupt corner cases.
module tb_spi_port_regs;
    import spi_port_regs_pkg::*;

    localparam int          NUM_CS       = 1;
    localparam int          NUM_SENSORS  = 2;
    localparam logic [15:0] SENSOR_RESET = 16'hC35A;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  spcr, sper, spsr, wfdin, rfdout;
    logic        wr_spsr, clear_spif, clear_wcol, wfwe, rfre, irq;
    logic [NUM_CS-1:0]        ncs_o;
    logic [16*NUM_SENSORS-1:0] sensor;

    spi_port_regs_if bus ();

    spi_port_regs #(
        .BASE_ADDRESS (8'h00),
        .NUM_CS       (NUM_CS),
        .NUM_SENSORS  (NUM_SENSORS),
        .SENSOR_RESET (SENSOR_RESET)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .spcr       (spcr),
        .sper       (sper),
        .spsr       (spsr),
        .wr_spsr    (wr_spsr),
        .clear_spif (clear_spif),
        .clear_wcol (clear_wcol),
        .wfdin      (wfdin),
        .wfwe       (wfwe),
        .rfdout     (rfdout),
        .rfre       (rfre),
        .ncs_o      (ncs_o),
        .sensor     (sensor),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        bus.port_id      = addr;
        bus.data_in      = data;
        bus.write_strobe = 1'b1;
        cyc();
        bus.write_strobe = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
        bus.port_id     = addr;
        bus.read_strobe = 1'b1;
        cyc();
        bus.read_strobe = 1'b0;
        data = bus.data_out;
    endtask

    task automatic wait_ncs(input logic [NUM_CS-1:0] want, input string name);
        int k;
        for (k = 0; k < 10; k++) begin
            if (ncs_o == want) break;
            cyc();
        end
        check(name, 32'(ncs_o), 32'(want));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic       seen;

        reset            = 1'b1;
        spsr             = 8'h00;
        rfdout           = 8'h3C;
        bus.port_id      = 8'h00;
        bus.data_in      = 8'h00;
        bus.write_strobe = 1'b0;
        bus.read_strobe  = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        // Reset values on the output pins
        check("rst_spcr",   32'(spcr), 32'h00);
        check("rst_sper",   32'(sper), 32'h00);
        check("rst_wfdin",  32'(wfdin), 32'h00);
        check("rst_pulses", 32'({wfwe, rfre, wr_spsr, clear_spif, clear_wcol}), 32'h0);
        check("rst_ncs",    32'(ncs_o), 32'h1);
        check("rst_sensor", 32'(sensor), {SENSOR_RESET, SENSOR_RESET});
        check("rst_irq",    32'(irq), 32'h0);
        check("rst_state",  32'(dut.u_burst.state_reg), 32'(BURST_IDLE));

        // Register map table: reset reads first, then read/write round trips
        vecs.push_back('{1'b0, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 8'h01, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 8'h02, 8'h00, 8'h3C});
        vecs.push_back('{1'b0, 8'h03, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 8'h04, 8'h00, 8'h01});
        vecs.push_back('{1'b0, 8'h05, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 8'h06, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 8'h07, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 8'h09, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 8'h08, 8'h00, 8'h5A});
        vecs.push_back('{1'b0, 8'h09, 8'h00, 8'hC3});
        vecs.push_back('{1'b0, 8'h0A, 8'h00, 8'h5A});
        vecs.push_back('{1'b0, 8'h0B, 8'h00, 8'hC3});
        vecs.push_back('{1'b0, 8'h0C, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 8'h0F, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h00, 8'h81, 8'h00});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 8'h81});
        vecs.push_back('{1'b1, 8'h03, 8'h5C, 8'h00});
        vecs.push_back('{1'b0, 8'h03, 8'h00, 8'h5C});
        vecs.push_back('{1'b1, 8'h05, 8'h05, 8'h00});
        vecs.push_back('{1'b0, 8'h05, 8'h00, 8'h05});
        vecs.push_back('{1'b1, 8'h05, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 8'h05, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h0F, 8'h77, 8'h00});
        vecs.push_back('{1'b0, 8'h0F, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h04, 8'h81, 8'h00});
        vecs.push_back('{1'b0, 8'h04, 8'h00, 8'h81});
        vecs.push_back('{1'b1, 8'h04, 8'h7E, 8'h00});
        vecs.push_back('{1'b0, 8'h04, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h04, 8'h01, 8'h00});
        vecs.push_back('{1'b0, 8'h04, 8'h00, 8'h01});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, d);
                check($sformatf("tbl%0d_rd_%h", i, vecs[i].addr), 32'(d), 32'(vecs[i].exp));
            end
        end

        // SPDR write pulse and read-FIFO pop only on strobe
        bus_write(8'h02, 8'hA5);
        check("wfwe_pulse", 32'(wfwe), 32'h1);
        check("wfdin",      32'(wfdin), 32'hA5);
        cyc();
        check("wfwe_end",   32'(wfwe), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            seen = seen | rfre;
        end
        check("rfre_no_strobe", 32'(seen), 32'h0);
        rfdout = 8'h96;
        bus_read(8'h02, d);
        check("rfre_pulse", 32'(rfre), 32'h1);
        check("spdr_rd",    32'(d), 32'h96);
        cyc();
        check("rfre_end",   32'(rfre), 32'h0);

        // SPSR write pulses
        bus_write(8'h01, 8'hC0);
        check("spsr_wr_c0", 32'({wr_spsr, clear_spif, clear_wcol}), 32'b111);
        bus_write(8'h01, 8'h40);
        check("spsr_wr_40", 32'({wr_spsr, clear_spif, clear_wcol}), 32'b101);
        cyc();
        check("spsr_wr_end", 32'({wr_spsr, clear_spif, clear_wcol}), 32'b000);

        // Sensor atomicity
        bus_write(8'h08, 8'h34);
        check("sens_lo_only", 32'(sensor[15:0]), 32'hC35A);
        bus_write(8'h09, 8'h12);
        check("sens_commit",  32'(sensor[15:0]), 32'h1234);
        check("sens1_intact", 32'(sensor[31:16]), 32'(SENSOR_RESET));
        bus_read(8'h08, d);
        check("sens_rd_lo", 32'(d), 32'h34);
        bus_write(8'h08, 8'hCD);
        bus_write(8'h09, 8'hAB);
        check("sens_new", 32'(sensor[15:0]), 32'hABCD);
        bus_read(8'h09, d);
        check("sens_rd_hi_old", 32'(d), 32'h12);
        bus_read(8'h08, d);
        bus_read(8'h09, d);
        check("sens_rd_hi_new", 32'(d), 32'hAB);

        // Burst with automatic chip-select release
        bus_write(8'h04, 8'h80);
        check("ncs_low", 32'(ncs_o), 32'h0);
        bus_write(8'h07, 8'h03);
        bus_read(8'h07, d);
        check("burst_load", 32'(d), 32'h03);
        for (int i = 0; i < 3; i++) bus_write(8'h02, 8'(i));
        bus_read(8'h07, d);
        check("burst_zero",  32'(d), 32'h00);
        check("burst_drain", 32'(dut.u_burst.state_reg), 32'(BURST_DRAIN));
        bus_write(8'h02, 8'hEE);
        bus_read(8'h07, d);
        check("drain_no_dec", 32'(d), 32'h00);
        check("drain_ncs",    32'(ncs_o), 32'h0);
        spsr = 8'h80;
        wait_ncs(1'b1, "auto_release");
        bus_read(8'h06, d);
        check("isr_done", 32'(d), 32'h05);
        check("irq_masked", 32'(irq), 32'h0);
        bus_write(8'h05, 8'h04);
        cyc();
        check("irq_on", 32'(irq), 32'h1);
        bus_write(8'h06, 8'h04);
        cyc();
        check("irq_off", 32'(irq), 32'h0);

        // Same-cycle SPIF edge and W1C of ISR[0]: the set wins
        spsr = 8'h00;
        bus_write(8'h06, 8'h01);
        bus_read(8'h06, d);
        check("isr_cleared", 32'(d), 32'h00);
        spsr = 8'h80;
        bus_write(8'h06, 8'h01);
        bus_read(8'h06, d);
        check("isr_set_wins", 32'(d), 32'h01);
        spsr = 8'h40;
        cyc();
        bus_read(8'h06, d);
        check("isr_wcol", 32'(d), 32'h03);
        spsr = 8'h00;
        bus_write(8'h06, 8'h07);
        bus_read(8'h06, d);
        check("isr_all_clr", 32'(d), 32'h00);

        // Abort mid-burst with BURST=0
        bus_write(8'h04, 8'h80);
        bus_write(8'h07, 8'h02);
        bus_write(8'h02, 8'h11);
        bus_read(8'h07, d);
        check("abort_count1", 32'(d), 32'h01);
        bus_write(8'h07, 8'h00);
        bus_read(8'h07, d);
        check("abort_count0", 32'(d), 32'h00);
        check("abort_idle",   32'(dut.u_burst.state_reg), 32'(BURST_IDLE));
        spsr = 8'h80;
        repeat (3) cyc();
        check("abort_ncs", 32'(ncs_o), 32'h0);
        bus_read(8'h06, d);
        check("abort_isr", 32'(d), 32'h01);
        spsr = 8'h00;
        bus_write(8'h06, 8'h07);

        // BURST write beats a same-cycle SPIF edge in DRAIN
        bus_write(8'h07, 8'h01);
        bus_write(8'h02, 8'h22);
        check("prio_drain", 32'(dut.u_burst.state_reg), 32'(BURST_DRAIN));
        spsr = 8'h80;
        bus_write(8'h07, 8'h02);
        cyc();
        check("prio_state", 32'(dut.u_burst.state_reg), 32'(BURST_COUNT));
        bus_read(8'h06, d);
        check("prio_isr", 32'(d), 32'h01);
        bus_read(8'h07, d);
        check("prio_count", 32'(d), 32'h02);
        spsr = 8'h00;
        bus_write(8'h06, 8'h07);

        // Reset while in DRAIN
        bus_write(8'h07, 8'h01);
        bus_write(8'h02, 8'h33);
        bus_write(8'h00, 8'hFF);
        bus_write(8'h05, 8'h07);
        check("pre_rst_drain", 32'(dut.u_burst.state_reg), 32'(BURST_DRAIN));
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst2_state",  32'(dut.u_burst.state_reg), 32'(BURST_IDLE));
        check("rst2_spcr",   32'(spcr), 32'h00);
        check("rst2_wfdin",  32'(wfdin), 32'h00);
        check("rst2_ncs",    32'(ncs_o), 32'h1);
        check("rst2_sensor", 32'(sensor), {SENSOR_RESET, SENSOR_RESET});
        check("rst2_irq",    32'(irq), 32'h0);
        bus_read(8'h07, d);
        check("rst2_burst", 32'(d), 32'h00);
        bus_read(8'h04, d);
        check("rst2_ncs_rd", 32'(d), 32'h01);
        bus_read(8'h05, d);
        check("rst2_ier", 32'(d), 32'h00);
        bus_read(8'h06, d);
        check("rst2_isr", 32'(d), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
